// File: rtl/alu_cmd_issuer.sv
// Command stage for the 32-bit ALU: queues producer commands, issues them one at a time,
// screens divide/remainder by zero and returns tagged results or a timeout error.
module alu_cmd_issuer #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [DATA_W-1:0]       cmd_a_i,
  input  logic [DATA_W-1:0]       cmd_b_i,
  input  logic [2:0]              cmd_op_i,
  input  logic [3:0]              cmd_tag_i,
  output logic                    alu_valid_o,
  output logic [DATA_W-1:0]       alu_operand_a_o,
  output logic [DATA_W-1:0]       alu_operand_b_o,
  output logic [2:0]              alu_operation_o,
  input  logic                    alu_ready_i,
  input  logic [DATA_W-1:0]       alu_result_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_W-1:0]       rsp_result_o,
  output logic [3:0]              rsp_tag_o,
  output logic [1:0]              rsp_err_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT) + 1;

  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_REM   = 3'd4;
  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_DIV0 = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [2:0]        op;
    logic [3:0]        tag;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  cmd_t              fifo_mem [DEPTH];
  cmd_t              cmd_in, head;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2:0]        op_q, op_d;
  logic [3:0]        tag_q, tag_d;
  logic [1:0]        err_q, err_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              push, pop, issuing_d, resp_d;

  assign cmd_in    = {cmd_a_i, cmd_b_i, cmd_op_i, cmd_tag_i};
  assign head      = fifo_mem[rd_ptr_q];
  assign push      = cmd_valid_i && cmd_ready_o;
  assign issuing_d = (state_d == ISSUE) || (state_d == WAIT);
  assign resp_d    = (state_d == RESP);

  // FIFO storage carries no reset; occupancy alone qualifies the contents
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= cmd_in;
  end

  // Next-state and working-register update
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    tag_d   = tag_q;
    res_d   = res_q;
    err_d   = err_q;
    timer_d = timer_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_o != '0) begin
          pop   = 1'b1;
          a_d   = head.a;
          b_d   = head.b;
          op_d  = head.op;
          tag_d = head.tag;
          if ((head.op == OP_DIV || head.op == OP_REM) && head.b == '0) begin
            res_d   = '1;
            err_d   = ERR_DIV0;
            state_d = RESP;
          end else begin
            res_d   = '0;
            err_d   = ERR_OK;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = TMR_W'(timer_q + 1'b1);
        // A ready arriving on the last timeout cycle still counts as a result
        if (alu_ready_i) begin
          res_d   = alu_result_i;
          err_d   = ERR_OK;
          state_d = RESP;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          res_d   = '0;
          err_d   = ERR_TMO;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_o;
    case ({push, pop})
      2'b10:   count_d = CNT_W'(count_o + 1'b1);
      2'b01:   count_d = CNT_W'(count_o - 1'b1);
      default: count_d = count_o;
    endcase
  end

  // State, pointers and registered outputs decoded from the next state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_o         <= '0;
      cmd_ready_o     <= 1'b1;
      a_q             <= '0;
      b_q             <= '0;
      op_q            <= '0;
      tag_q           <= '0;
      res_q           <= '0;
      err_q           <= '0;
      timer_q         <= '0;
      alu_valid_o     <= 1'b0;
      alu_operand_a_o <= '0;
      alu_operand_b_o <= '0;
      alu_operation_o <= '0;
      rsp_valid_o     <= 1'b0;
      rsp_result_o    <= '0;
      rsp_tag_o       <= '0;
      rsp_err_o       <= '0;
    end else begin
      state_q         <= state_d;
      if (push) wr_ptr_q <= PTR_W'(wr_ptr_q + 1'b1);
      if (pop)  rd_ptr_q <= PTR_W'(rd_ptr_q + 1'b1);
      count_o         <= count_d;
      cmd_ready_o     <= (count_d != CNT_W'(DEPTH));
      a_q             <= a_d;
      b_q             <= b_d;
      op_q            <= op_d;
      tag_q           <= tag_d;
      res_q           <= res_d;
      err_q           <= err_d;
      timer_q         <= timer_d;
      alu_valid_o     <= (state_d == ISSUE);
      alu_operand_a_o <= issuing_d ? a_d  : '0;
      alu_operand_b_o <= issuing_d ? b_d  : '0;
      alu_operation_o <= issuing_d ? op_d : '0;
      rsp_valid_o     <= resp_d;
      rsp_result_o    <= resp_d ? res_d : '0;
      rsp_tag_o       <= resp_d ? tag_d : '0;
      rsp_err_o       <= resp_d ? err_d : '0;
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: directed scenarios plus a randomized stream checked
// against a queue-based response model and a behavioural ALU with per-command latency.
module tb_alu_cmd_issuer;

  localparam int unsigned DW      = 32;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 16;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  tag;
    logic [1:0]  err;
  } exp_t;

  logic          clk_i, rst_i;
  logic          cmd_valid_i, cmd_ready_o;
  logic [DW-1:0] cmd_a_i, cmd_b_i;
  logic [2:0]    cmd_op_i;
  logic [3:0]    cmd_tag_i;
  logic          alu_valid_o, alu_ready_i;
  logic [DW-1:0] alu_operand_a_o, alu_operand_b_o, alu_result_i;
  logic [2:0]    alu_operation_o;
  logic          rsp_valid_o, rsp_ready_i;
  logic [DW-1:0] rsp_result_o;
  logic [3:0]    rsp_tag_o;
  logic [1:0]    rsp_err_o;
  logic [2:0]    count_o;

  int   total = 0;
  int   bad   = 0;
  int   alu_lat;
  int   lat_q[$];
  exp_t exp_q[$];

  alu_cmd_issuer #(.DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_a_i(cmd_a_i), .cmd_b_i(cmd_b_i), .cmd_op_i(cmd_op_i), .cmd_tag_i(cmd_tag_i),
    .alu_valid_o(alu_valid_o), .alu_operand_a_o(alu_operand_a_o),
    .alu_operand_b_o(alu_operand_b_o), .alu_operation_o(alu_operation_o),
    .alu_ready_i(alu_ready_i), .alu_result_i(alu_result_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_result_o(rsp_result_o), .rsp_tag_o(rsp_tag_o), .rsp_err_o(rsp_err_o),
    .count_o(count_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a * b;
      3'd3:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd4:    return (b == 0) ? a : a % b;
      3'd5:    return a & b;
      3'd6:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic bit is_div0(input logic [2:0] op, input logic [31:0] b);
    return (op == 3'd3 || op == 3'd4) && b == 0;
  endfunction

  // Expected response: lat is the ALU's ready delay after valid, 0 meaning it never answers
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] op, input logic [3:0] tag, input int lat);
    if (is_div0(op, b))                    return {32'hFFFF_FFFF, tag, 2'b01};
    if (lat == 0 || lat > int'(TIMEOUT))   return {32'h0, tag, 2'b10};
    return {alu_fn(a, b, op), tag, 2'b00};
  endfunction

  // Behavioural ALU: answers lat cycles after seeing valid, garbage result otherwise
  initial begin
    int          cd;
    logic [31:0] pend;
    cd = 0;
    pend = '0;
    alu_ready_i = 1'b0;
    alu_result_i = '0;
    forever begin
      @(posedge clk_i);
      #1;
      alu_ready_i  = 1'b0;
      alu_result_i = $urandom;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          alu_ready_i  = 1'b1;
          alu_result_i = pend;
        end
      end
      if (alu_valid_o === 1'b1) begin
        if (lat_q.size() > 0) cd = lat_q.pop_front();
        else                  cd = alu_lat;
        pend = alu_fn(alu_operand_a_o, alu_operand_b_o, alu_operation_o);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    cmd_valid_i = 1'b1;
    cmd_a_i = $urandom; cmd_b_i = $urandom; cmd_op_i = 3'd0; cmd_tag_i = 4'd0;
    rsp_ready_i = 1'b0;
    tick();
    tick();
    cmd_valid_i = 1'b0;
    rst_i = 1'b0;
    tick();
    total++;
    if ({cmd_ready_o, count_o, alu_valid_o, rsp_valid_o} !== {1'b1, 3'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_ctrl: got rdy/cnt/av/rv=%b/%0d/%b/%b want 1/0/0/0",
               cmd_ready_o, count_o, alu_valid_o, rsp_valid_o);
    end
    total++;
    if ({alu_operand_a_o, alu_operand_b_o, alu_operation_o, rsp_result_o, rsp_tag_o,
         rsp_err_o} !== 105'd0) begin
      bad++;
      $display("FAIL reset_data: got a=%h b=%h op=%h res=%h tag=%h err=%h want all zero",
               alu_operand_a_o, alu_operand_b_o, alu_operation_o, rsp_result_o, rsp_tag_o,
               rsp_err_o);
    end
  endtask

  task automatic test_single_add();
    int n_valid = 0;
    int rsp_cyc = -1;
    exp_t got = '0;
    alu_lat = 1;
    rsp_ready_i = 1'b1;
    cmd_valid_i = 1'b1; cmd_a_i = 5; cmd_b_i = 7; cmd_op_i = 3'd0; cmd_tag_i = 4'd3;
    tick();
    cmd_valid_i = 1'b0;
    total++;
    if (count_o !== 3'd1) begin
      bad++;
      $display("FAIL add_count: got %0d want 1", count_o);
    end
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (alu_valid_o === 1'b1) begin
        n_valid++;
        total++;
        if ({alu_operand_a_o, alu_operand_b_o, alu_operation_o} !== {32'd5, 32'd7, 3'd0}) begin
          bad++;
          $display("FAIL add_operands: got a=%0d b=%0d op=%0d want 5 7 0",
                   alu_operand_a_o, alu_operand_b_o, alu_operation_o);
        end
      end
      if (rsp_valid_o === 1'b1 && rsp_cyc < 0) begin
        rsp_cyc = i;
        got = {rsp_result_o, rsp_tag_o, rsp_err_o};
      end
    end
    total++;
    if (n_valid != 1) begin
      bad++;
      $display("FAIL add_valid_cycles: got %0d want 1", n_valid);
    end
    total++;
    if (rsp_cyc != 3) begin
      bad++;
      $display("FAIL add_latency: got %0d want 3", rsp_cyc);
    end
    total++;
    if (got !== {32'd12, 4'd3, 2'b00}) begin
      bad++;
      $display("FAIL add_rsp: got res=%0d tag=%0d err=%b want 12 3 00", got.res, got.tag, got.err);
    end
  endtask

  task automatic test_fifo_full_order();
    localparam int N = 6;
    logic [31:0] ca[N], cb[N];
    logic [2:0]  co[N];
    int sent = 0;
    int got = 0;
    exp_t e;
    alu_lat = 1;
    rsp_ready_i = 1'b0;
    for (int i = 0; i < N; i++) begin
      ca[i] = $urandom; cb[i] = $urandom_range(1, 1000); co[i] = 3'($urandom_range(0, 7));
    end
    for (int cyc = 0; cyc < 200 && got < N; cyc++) begin
      if (cyc == 30) begin
        total++;
        if (sent != 5) begin
          bad++;
          $display("FAIL full_accepted: got %0d want 5", sent);
        end
        total++;
        if ({count_o, cmd_ready_o} !== {3'd4, 1'b0}) begin
          bad++;
          $display("FAIL full_ready: got cnt=%0d rdy=%b want 4 0", count_o, cmd_ready_o);
        end
      end
      rsp_ready_i = (cyc >= 30);
      if (rsp_valid_o === 1'b1 && rsp_ready_i) begin
        e = exp_q.pop_front();
        total++;
        if ({rsp_result_o, rsp_tag_o, rsp_err_o} !== e) begin
          bad++;
          $display("FAIL full_order: got res=%h tag=%0d err=%b want %h %0d %b",
                   rsp_result_o, rsp_tag_o, rsp_err_o, e.res, e.tag, e.err);
        end
        got++;
      end
      cmd_valid_i = (sent < N);
      if (sent < N) begin
        cmd_a_i = ca[sent]; cmd_b_i = cb[sent]; cmd_op_i = co[sent]; cmd_tag_i = 4'(sent);
      end
      if (cmd_valid_i && cmd_ready_o === 1'b1) begin
        exp_q.push_back(model(ca[sent], cb[sent], co[sent], 4'(sent), 1));
        sent++;
      end
      tick();
    end
    cmd_valid_i = 1'b0;
    total++;
    if (got != N) begin
      bad++;
      $display("FAIL full_drain: got %0d responses want %0d", got, N);
    end
    exp_q.delete();
  endtask

  task automatic test_div_zero();
    int n_valid = 0;
    int rsp_cyc = -1;
    exp_t got = '0;
    rsp_ready_i = 1'b1;
    cmd_valid_i = 1'b1; cmd_a_i = 100; cmd_b_i = 0; cmd_op_i = 3'd3; cmd_tag_i = 4'd9;
    tick();
    cmd_valid_i = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (alu_valid_o === 1'b1) n_valid++;
      if (rsp_valid_o === 1'b1 && rsp_cyc < 0) begin
        rsp_cyc = i;
        got = {rsp_result_o, rsp_tag_o, rsp_err_o};
      end
    end
    total++;
    if (n_valid != 0) begin
      bad++;
      $display("FAIL div0_no_issue: got %0d alu_valid cycles want 0", n_valid);
    end
    total++;
    if (rsp_cyc != 1) begin
      bad++;
      $display("FAIL div0_latency: got %0d want 1", rsp_cyc);
    end
    total++;
    if (got !== {32'hFFFF_FFFF, 4'd9, 2'b01}) begin
      bad++;
      $display("FAIL div0_rsp: got res=%h tag=%0d err=%b want ffffffff 9 01",
               got.res, got.tag, got.err);
    end
  endtask

  // Never-ready ALU, ready exactly on the timeout cycle, then a nominal command
  task automatic test_timeout();
    int   lats[3] = '{0, TIMEOUT, 1};
    int   want_cyc[3] = '{TIMEOUT + 2, TIMEOUT + 2, 3};
    logic [2:0] ops[3] = '{3'd2, 3'd0, 3'd7};
    rsp_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int   rsp_cyc = -1;
      exp_t got = '0;
      exp_t e;
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      alu_lat = lats[k];
      e = model(a, b, ops[k], 4'(k + 1), lats[k]);
      cmd_valid_i = 1'b1; cmd_a_i = a; cmd_b_i = b; cmd_op_i = ops[k]; cmd_tag_i = 4'(k + 1);
      tick();
      cmd_valid_i = 1'b0;
      for (int i = 1; i <= 30; i++) begin
        tick();
        if (rsp_valid_o === 1'b1 && rsp_cyc < 0) begin
          rsp_cyc = i;
          got = {rsp_result_o, rsp_tag_o, rsp_err_o};
        end
      end
      total++;
      if (rsp_cyc != want_cyc[k]) begin
        bad++;
        $display("FAIL tmo_latency[%0d]: got %0d want %0d", k, rsp_cyc, want_cyc[k]);
      end
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL tmo_rsp[%0d]: got res=%h tag=%0d err=%b want %h %0d %b",
                 k, got.res, got.tag, got.err, e.res, e.tag, e.err);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t snap;
    int   wait_n = 0;
    alu_lat = 1;
    rsp_ready_i = 1'b0;
    cmd_valid_i = 1'b1; cmd_a_i = 10; cmd_b_i = 20; cmd_op_i = 3'd0; cmd_tag_i = 4'd5;
    tick();
    cmd_a_i = 50; cmd_b_i = 8; cmd_op_i = 3'd1; cmd_tag_i = 4'd6;
    tick();
    cmd_valid_i = 1'b0;
    while (rsp_valid_o !== 1'b1 && wait_n < 20) begin
      tick();
      wait_n++;
    end
    snap = {rsp_result_o, rsp_tag_o, rsp_err_o};
    total++;
    if (rsp_valid_o !== 1'b1 || snap !== {32'd30, 4'd5, 2'b00}) begin
      bad++;
      $display("FAIL bp_first: got v=%b res=%0d tag=%0d err=%b want 1 30 5 00",
               rsp_valid_o, snap.res, snap.tag, snap.err);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if ({rsp_valid_o, rsp_result_o, rsp_tag_o, rsp_err_o} !== {1'b1, snap}) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got v=%b res=%h tag=%0d err=%b", i,
                 rsp_valid_o, rsp_result_o, rsp_tag_o, rsp_err_o);
      end
      total++;
      if (alu_valid_o !== 1'b0) begin
        bad++;
        $display("FAIL bp_no_issue[%0d]: got alu_valid=%b want 0", i, alu_valid_o);
      end
    end
    rsp_ready_i = 1'b1;
    tick();
    total++;
    if (rsp_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL bp_drop: got rsp_valid=%b want 0", rsp_valid_o);
    end
    tick();
    total++;
    if ({alu_valid_o, alu_operand_a_o, alu_operand_b_o, alu_operation_o} !==
        {1'b1, 32'd50, 32'd8, 3'd1}) begin
      bad++;
      $display("FAIL bp_next_issue: got v=%b a=%0d b=%0d op=%0d want 1 50 8 1",
               alu_valid_o, alu_operand_a_o, alu_operand_b_o, alu_operation_o);
    end
    wait_n = 0;
    while (rsp_valid_o !== 1'b1 && wait_n < 20) begin
      tick();
      wait_n++;
    end
    total++;
    if ({rsp_valid_o, rsp_result_o, rsp_tag_o, rsp_err_o} !== {1'b1, 32'd42, 4'd6, 2'b00}) begin
      bad++;
      $display("FAIL bp_second: got v=%b res=%0d tag=%0d err=%b want 1 42 6 00",
               rsp_valid_o, rsp_result_o, rsp_tag_o, rsp_err_o);
    end
    tick();
  endtask

  // Reset while the first command waits on a slow ALU whose late ready must be ignored
  task automatic test_reset_mid_wait();
    int seen_rsp = 0;
    int seen_issue = 0;
    alu_lat = 5;
    rsp_ready_i = 1'b1;
    cmd_valid_i = 1'b1; cmd_op_i = 3'd0;
    for (int i = 0; i < 4; i++) begin
      cmd_a_i = $urandom; cmd_b_i = $urandom; cmd_tag_i = 4'(i);
      tick();
    end
    cmd_valid_i = 1'b0;
    total++;
    if (count_o !== 3'd3) begin
      bad++;
      $display("FAIL rst_wait_queued: got %0d want 3", count_o);
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    total++;
    if ({count_o, rsp_valid_o, alu_valid_o, cmd_ready_o} !== {3'd0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL rst_wait_clear: got cnt=%0d rv=%b av=%b rdy=%b want 0 0 0 1",
               count_o, rsp_valid_o, alu_valid_o, cmd_ready_o);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid_o !== 1'b0) seen_rsp++;
      if (alu_valid_o !== 1'b0) seen_issue++;
    end
    total++;
    if (seen_rsp != 0) begin
      bad++;
      $display("FAIL rst_wait_late_ready: got %0d response cycles want 0", seen_rsp);
    end
    total++;
    if (seen_issue != 0) begin
      bad++;
      $display("FAIL rst_wait_reissue: got %0d issue cycles want 0", seen_issue);
    end
  endtask

  task automatic test_random();
    localparam int N = 60;
    logic [31:0] ca[N], cb[N];
    logic [2:0]  co[N];
    logic [3:0]  ct[N];
    int          cl[N];
    int sent = 0;
    int got = 0;
    exp_t e;
    for (int i = 0; i < N; i++) begin
      ca[i] = $urandom;
      cb[i] = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      co[i] = 3'($urandom_range(0, 7));
      ct[i] = 4'($urandom_range(0, 15));
      cl[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TIMEOUT + 2) : $urandom_range(1, 3);
    end
    for (int cyc = 0; cyc < 5000 && got < N; cyc++) begin
      rsp_ready_i = ($urandom_range(0, 9) < 7);
      if (rsp_valid_o === 1'b1 && rsp_ready_i) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rnd_unexpected: got tag=%0d with nothing outstanding", rsp_tag_o);
        end else begin
          e = exp_q.pop_front();
          if ({rsp_result_o, rsp_tag_o, rsp_err_o} !== e) begin
            bad++;
            $display("FAIL rnd_rsp[%0d]: got res=%h tag=%0d err=%b want %h %0d %b",
                     got, rsp_result_o, rsp_tag_o, rsp_err_o, e.res, e.tag, e.err);
          end
        end
        got++;
      end
      cmd_valid_i = (sent < N) && ($urandom_range(0, 4) != 0);
      if (sent < N) begin
        cmd_a_i = ca[sent]; cmd_b_i = cb[sent]; cmd_op_i = co[sent]; cmd_tag_i = ct[sent];
      end
      if (cmd_valid_i && cmd_ready_o === 1'b1) begin
        exp_q.push_back(model(ca[sent], cb[sent], co[sent], ct[sent], cl[sent]));
        if (!is_div0(co[sent], cb[sent])) lat_q.push_back(cl[sent]);
        sent++;
      end
      tick();
    end
    cmd_valid_i = 1'b0;
    total++;
    if (got != N) begin
      bad++;
      $display("FAIL rnd_drain: got %0d responses want %0d", got, N);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_a_i = '0; cmd_b_i = '0; cmd_op_i = '0; cmd_tag_i = '0;
    rsp_ready_i = 1'b0;
    alu_lat = 1;
    test_reset();
    test_single_add();
    test_fifo_full_order();
    test_div_zero();
    test_timeout();
    test_backpressure();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
Upstream command stage for the 32-bit ALU. It buffers operation requests from a producer in a small FIFO and issues them one at a time over the ALU's valid/ready handshake. Each ALU result is captured and returned with its tag on a response channel. The stage screens divide/remainder by zero and times out a non-responding ALU.

Parameters:
DATA_W, 32, operand/result width
DEPTH, 4, command FIFO entries (power of 2, >=2)
TIMEOUT, 16, cycles to wait in WAIT for alu_ready_i before aborting

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  reset, synchronous, active-high
cmd_valid_i  in  1  producer command valid
cmd_ready_o  out  1  FIFO can accept (not full)
cmd_a_i  in  DATA_W  operand A
cmd_b_i  in  DATA_W  operand B
cmd_op_i  in  3  opcode: 0 add, 1 sub, 2 mul, 3 div, 4 rem, 5 and, 6 or, 7 xor
cmd_tag_i  in  4  producer tag, returned unchanged
alu_valid_o  out  1  to ALU valid_i
alu_operand_a_o  out  DATA_W  to ALU operand_a
alu_operand_b_o  out  DATA_W  to ALU operand_b
alu_operation_o  out  3  to ALU operation
alu_ready_i  in  1  from ALU ready_o
alu_result_i  in  DATA_W  from ALU result
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  consumer accepts response
rsp_result_o  out  DATA_W  result
rsp_tag_o  out  4  tag of the completed command
rsp_err_o  out  2  00 ok, 01 divide-by-zero, 10 timeout
count_o  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - FIFO empty, count_o=0, FSM=IDLE, timer=0.
  - All outputs 0 except cmd_ready_o=1 in the cycle after reset is released.
  - Reset mid-operation discards queued and in-flight commands; a later alu_ready_i is ignored.
- FIFO:
  - cmd_ready_o = (count_o != DEPTH), registered-state based.
  - Push on cmd_valid_i && cmd_ready_o.
  - When full, no push occurs even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full leaves count_o unchanged.
  - Pointers wrap modulo DEPTH. Order is strictly FIFO.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE:
    - FIFO empty -> stay in IDLE.
    - Otherwise pop the head into working registers (a, b, op, tag).
    - If op is 3 or 4 and b==0: result=32'hFFFF_FFFF, err=01, go to RESP. No ALU transaction occurs.
    - Otherwise go to ISSUE.
  - ISSUE:
    - alu_valid_o=1 for exactly this one cycle; timer cleared.
    - Next state WAIT.
  - WAIT:
    - alu_valid_o=0; timer increments each cycle.
    - If alu_ready_i=1: capture alu_result_i, err=00, go to RESP.
    - Else if timer reaches TIMEOUT-1: result=0, err=10, go to RESP.
    - alu_ready_i wins if it coincides with the timeout cycle.
  - RESP:
    - rsp_valid_o=1, with rsp_result_o/rsp_tag_o/rsp_err_o held stable until rsp_ready_i=1.
    - On handshake go to IDLE. rsp_valid_o drops the cycle after the handshake.
- ALU operand/operation outputs:
  - Driven from the working registers.
  - Stable from ISSUE through the end of WAIT.
  - Zero in IDLE.
- alu_ready_i is ignored in every state except WAIT.
- Latency:
  - With a nominal ALU (ready one cycle after valid) and rsp_ready_i tied high: pop cycle -> ISSUE +1 -> ready seen in WAIT +2 -> rsp_valid_o +3.
  - Minimum 4 cycles per command.
  - Div-by-zero path: rsp_valid_o 1 cycle after the pop.
- No arithmetic is performed here; operands pass through unmodified at DATA_W.

Test Plan:
- Single add: after reset, push a=5, b=7, op=0, tag=3. ALU model returns 12 one cycle after valid. Required: alu_valid_o high exactly 1 cycle; rsp_valid_o=1 with result=12, tag=3, err=00, 3 cycles after the pop.
- FIFO full/order: hold rsp_ready_i=0 and push 5 commands back-to-back with tags 0..4. Required: cmd_ready_o=0 once count_o=4. After rsp_ready_i=1, responses return with tags 0,1,2,3 in order. Tag 4 is accepted only after space frees.
- Divide by zero: push a=100, b=0, op=3, tag=9. Required: alu_valid_o never asserts; response result=0xFFFFFFFF, err=01, tag=9.
- Timeout: ALU model never asserts ready; push op=2, tag=1. Required: response err=10, result=0, rsp_valid_o asserted TIMEOUT cycles after leaving ISSUE. The next command still issues normally.
- Backpressure: rsp_ready_i=0 for 10 cycles during RESP. Required: rsp outputs stable throughout; no new alu_valid_o until the handshake completes.
- Reset mid-WAIT: assert rst_i for 1 cycle while in WAIT with 3 entries queued. Required: count_o=0, rsp_valid_o=0; an alu_ready_i pulse arriving afterwards produces no response.
